// File: rtl/issue_pkg.sv
// Shared constants for the issue-queue select logic: queue geometry and FU class codes.
package issue_pkg;
  localparam int IQ_DEPTH = 16;
  localparam int IDX_W    = $clog2(IQ_DEPTH);

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_MUL = 2'd1;
  localparam logic [1:0] FU_LS  = 2'd2;

  function automatic logic [IQ_DEPTH-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [IQ_DEPTH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/issue_select_ctrl_oldest_sel.sv
// Combinational oldest-first picker: largest age wins, ties resolve to the lowest index.
module oldest_sel
  import issue_pkg::*;
#(
  parameter int AGE_WIDTH = 5
) (
  input  logic [IQ_DEPTH-1:0]                mask,
  input  logic [IQ_DEPTH-1:0][AGE_WIDTH-1:0] ages,
  output logic                               found,
  output logic [IDX_W-1:0]                   idx
);
  logic [AGE_WIDTH-1:0] best_age;

  // Strict greater-than keeps the earlier (lower) index on equal ages.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    best_age = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (mask[i] && (!found || ages[i] > best_age)) begin
        found    = 1'b1;
        idx      = IDX_W'(i);
        best_age = ages[i];
      end
    end
  end
endmodule

// File: rtl/issue_select_ctrl.sv
// Issue-queue select/grant controller: per-entry state, oldest-first picks for ALU0/ALU1/MUL/LS,
// multiplier busy window and LS valid/ready hold. Optional second ALU port: ISSUE_SEL_ALU1_EN.
// LS handshake: gnt_ls_valid/gnt_ls_idx hold until sampled with ls_ready high; a new grant may load on that edge.
module issue_select_ctrl
  import issue_pkg::*;
#(
  parameter int AGE_WIDTH   = 5,
  parameter int MUL_LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                alloc_valid,
  input  logic [IDX_W-1:0]    alloc_idx,
  input  logic [1:0]          alloc_class,
  input  logic                dealloc_valid,
  input  logic [IDX_W-1:0]    dealloc_idx,
  input  logic [IQ_DEPTH-1:0] rdy,
  input  logic                ls_ready,
  output logic                gnt_alu0_valid,
  output logic [IDX_W-1:0]    gnt_alu0_idx,
  output logic                gnt_alu1_valid,
  output logic [IDX_W-1:0]    gnt_alu1_idx,
  output logic                gnt_mul_valid,
  output logic [IDX_W-1:0]    gnt_mul_idx,
  output logic                gnt_ls_valid,
  output logic [IDX_W-1:0]    gnt_ls_idx,
  output logic [IQ_DEPTH-1:0] issued_mask,
  output logic                mul_busy
);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  logic [IQ_DEPTH-1:0]                valid_q, issued_q;
  logic [IQ_DEPTH-1:0][1:0]           cls_q;
  logic [IQ_DEPTH-1:0][AGE_WIDTH-1:0] age_q;
  logic [3:0]                         mul_cnt;

  logic [IQ_DEPTH-1:0] alloc_hit, dealloc_hit, base_elig;
  logic [IQ_DEPTH-1:0] elig_alu, elig_mul, elig_ls, new_mask;
  logic                mul_en, ls_en;
  logic                alu0_found, alu1_found, mul_found, ls_found;
  logic [IDX_W-1:0]    alu0_idx, alu1_idx, mul_idx, ls_idx;

  // Entries being written or released this cycle are never picked, nor is anything during flush.
  always_comb begin
    alloc_hit   = alloc_valid ? idx_onehot(alloc_idx) : '0;
    dealloc_hit = dealloc_valid ? idx_onehot(dealloc_idx) : '0;
    base_elig   = valid_q & ~issued_q & rdy & ~alloc_hit & ~dealloc_hit & {IQ_DEPTH{~flush}};
    mul_en      = (mul_cnt <= 4'd1);
    ls_en       = ~gnt_ls_valid | ls_ready;
    elig_alu    = '0;
    elig_mul    = '0;
    elig_ls     = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      elig_alu[i] = base_elig[i] & (cls_q[i] == FU_ALU);
      elig_mul[i] = base_elig[i] & (cls_q[i] == FU_MUL) & mul_en;
      elig_ls[i]  = base_elig[i] & (cls_q[i] == FU_LS) & ls_en;
    end
  end

  oldest_sel #(.AGE_WIDTH(AGE_WIDTH)) u_sel_alu0 (.mask(elig_alu), .ages(age_q), .found(alu0_found), .idx(alu0_idx));
  oldest_sel #(.AGE_WIDTH(AGE_WIDTH)) u_sel_mul  (.mask(elig_mul), .ages(age_q), .found(mul_found),  .idx(mul_idx));
  oldest_sel #(.AGE_WIDTH(AGE_WIDTH)) u_sel_ls   (.mask(elig_ls),  .ages(age_q), .found(ls_found),   .idx(ls_idx));

`ifdef ISSUE_SEL_ALU1_EN
  logic [IQ_DEPTH-1:0] elig_alu1;
  assign elig_alu1 = elig_alu & ~(alu0_found ? idx_onehot(alu0_idx) : '0);

  oldest_sel #(.AGE_WIDTH(AGE_WIDTH)) u_sel_alu1 (.mask(elig_alu1), .ages(age_q), .found(alu1_found), .idx(alu1_idx));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_alu1_valid <= 1'b0;
      gnt_alu1_idx   <= '0;
    end else begin
      gnt_alu1_valid <= alu1_found;
      gnt_alu1_idx   <= alu1_found ? alu1_idx : '0;
    end
  end
`else
  assign alu1_found     = 1'b0;
  assign alu1_idx       = '0;
  assign gnt_alu1_valid = 1'b0;
  assign gnt_alu1_idx   = '0;
`endif

  assign new_mask = (alu0_found ? idx_onehot(alu0_idx) : '0) | (alu1_found ? idx_onehot(alu1_idx) : '0)
                  | (mul_found  ? idx_onehot(mul_idx)  : '0) | (ls_found   ? idx_onehot(ls_idx)   : '0);
  assign mul_busy = (mul_cnt != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      issued_q <= '0;
      cls_q    <= '0;
      age_q    <= '0;
    end else if (flush) begin
      valid_q  <= '0;
      issued_q <= '0;
      cls_q    <= '0;
      age_q    <= '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        if (alloc_hit[i]) begin
          valid_q[i]  <= 1'b1;
          issued_q[i] <= 1'b0;
          cls_q[i]    <= alloc_class;
          age_q[i]    <= '0;
        end else if (dealloc_hit[i]) begin
          valid_q[i]  <= 1'b0;
          issued_q[i] <= 1'b0;
          age_q[i]    <= '0;
        end else begin
          if (valid_q[i] && age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + 1'b1;
          if (new_mask[i]) issued_q[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_alu0_valid <= 1'b0;
      gnt_alu0_idx   <= '0;
      gnt_mul_valid  <= 1'b0;
      gnt_mul_idx    <= '0;
      gnt_ls_valid   <= 1'b0;
      gnt_ls_idx     <= '0;
      issued_mask    <= '0;
      mul_cnt        <= '0;
    end else if (flush) begin
      gnt_alu0_valid <= 1'b0;
      gnt_alu0_idx   <= '0;
      gnt_mul_valid  <= 1'b0;
      gnt_mul_idx    <= '0;
      gnt_ls_valid   <= 1'b0;
      gnt_ls_idx     <= '0;
      issued_mask    <= '0;
      mul_cnt        <= '0;
    end else begin
      gnt_alu0_valid <= alu0_found;
      gnt_alu0_idx   <= alu0_found ? alu0_idx : '0;
      gnt_mul_valid  <= mul_found;
      gnt_mul_idx    <= mul_found ? mul_idx : '0;
      issued_mask    <= new_mask;
      if (mul_found) mul_cnt <= 4'(MUL_LATENCY);
      else if (mul_cnt != 4'd0) mul_cnt <= mul_cnt - 4'd1;
      // LS grant is held until accepted; an accepted slot may be refilled on the same edge.
      if (ls_found) begin
        gnt_ls_valid <= 1'b1;
        gnt_ls_idx   <= ls_idx;
      end else if (gnt_ls_valid && ls_ready) begin
        gnt_ls_valid <= 1'b0;
        gnt_ls_idx   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_issue_select_ctrl.sv
// Self-checking bench for issue_select_ctrl: directed scenarios plus random traffic against a cycle-level model.
module tb_issue_select_ctrl;
  localparam int AGE_MAX = 31;
  localparam int L       = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, alloc_valid, dealloc_valid, ls_ready;
  logic [3:0]  alloc_idx, dealloc_idx;
  logic [1:0]  alloc_class;
  logic [15:0] rdy;
  logic        gnt_alu0_valid, gnt_alu1_valid, gnt_mul_valid, gnt_ls_valid, mul_busy;
  logic [3:0]  gnt_alu0_idx, gnt_alu1_idx, gnt_mul_idx, gnt_ls_idx;
  logic [15:0] issued_mask;

  issue_select_ctrl #(.AGE_WIDTH(5), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_class(alloc_class),
    .dealloc_valid(dealloc_valid), .dealloc_idx(dealloc_idx),
    .rdy(rdy), .ls_ready(ls_ready),
    .gnt_alu0_valid(gnt_alu0_valid), .gnt_alu0_idx(gnt_alu0_idx),
    .gnt_alu1_valid(gnt_alu1_valid), .gnt_alu1_idx(gnt_alu1_idx),
    .gnt_mul_valid(gnt_mul_valid), .gnt_mul_idx(gnt_mul_idx),
    .gnt_ls_valid(gnt_ls_valid), .gnt_ls_idx(gnt_ls_idx),
    .issued_mask(issued_mask), .mul_busy(mul_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];

  // reference model: entry table, last MUL grant time, held LS grant
  bit m_valid[16];
  bit m_issued[16];
  int m_cls[16];
  int m_age[16];
  int m_mul_last = -1000;
  bit m_ls_held  = 0;
  int m_ls_idx   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic bit is_blocked(input int i);
    return flush || (alloc_valid && int'(alloc_idx) == i) || (dealloc_valid && int'(dealloc_idx) == i);
  endfunction

  // Walk ages from oldest down, first eligible index at that age wins.
  function automatic int pick(input int c, input int excl);
    for (int a = AGE_MAX; a >= 0; a--)
      for (int i = 0; i < 16; i++)
        if (m_valid[i] && !m_issued[i] && rdy[i] && m_cls[i] == c && i != excl &&
            !is_blocked(i) && m_age[i] == a)
          return i;
    return -1;
  endfunction

  task automatic step();
    int p0, p1, pm, pl;
    logic [15:0] emask;
    p0 = pick(0, -1);
`ifdef ISSUE_SEL_ALU1_EN
    p1 = (p0 >= 0) ? pick(0, p0) : -1;
`else
    p1 = -1;
`endif
    pm = ((cyc + 1) >= m_mul_last + L) ? pick(1, -1) : -1;
    pl = (!m_ls_held || ls_ready) ? pick(2, -1) : -1;
    emask = '0;
    if (p0 >= 0) emask[p0] = 1'b1;
    if (p1 >= 0) emask[p1] = 1'b1;
    if (pm >= 0) emask[pm] = 1'b1;
    if (pl >= 0) emask[pl] = 1'b1;
    if (flush) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_issued[i] = 0; m_cls[i] = 0; m_age[i] = 0;
      end
      m_mul_last = -1000; m_ls_held = 0; m_ls_idx = 0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (alloc_valid && int'(alloc_idx) == i) begin
          m_valid[i] = 1; m_issued[i] = 0; m_cls[i] = int'(alloc_class); m_age[i] = 0;
        end else if (dealloc_valid && int'(dealloc_idx) == i) begin
          m_valid[i] = 0; m_issued[i] = 0; m_age[i] = 0;
        end else begin
          if (m_valid[i] && m_age[i] < AGE_MAX) m_age[i]++;
          if (emask[i]) m_issued[i] = 1;
        end
      end
      if (pm >= 0) m_mul_last = cyc + 1;
      if (pl >= 0) begin
        m_ls_held = 1; m_ls_idx = pl;
      end else if (m_ls_held && ls_ready) begin
        m_ls_held = 0; m_ls_idx = 0;
      end
    end
    @(posedge clk); #1;
    cyc++;
    check("alu0_valid", gnt_alu0_valid, p0 >= 0);
    check("alu0_idx",   gnt_alu0_idx,   (p0 >= 0) ? p0 : 0);
    check("alu1_valid", gnt_alu1_valid, p1 >= 0);
    check("alu1_idx",   gnt_alu1_idx,   (p1 >= 0) ? p1 : 0);
    check("mul_valid",  gnt_mul_valid,  pm >= 0);
    check("mul_idx",    gnt_mul_idx,    (pm >= 0) ? pm : 0);
    check("ls_valid",   gnt_ls_valid,   m_ls_held);
    check("ls_idx",     gnt_ls_idx,     m_ls_idx);
    check("issued_mask", issued_mask,   emask);
    check("mul_busy",   mul_busy,       cyc < m_mul_last + L);
  endtask

  // driver tasks
  task automatic set_idle();
    flush = 0; alloc_valid = 0; dealloc_valid = 0;
  endtask

  task automatic do_alloc(input int idx, input int c);
    alloc_valid = 1; alloc_idx = 4'(idx); alloc_class = 2'(c);
    step();
    set_idle();
  endtask

  task automatic do_flush();
    set_idle(); rdy = '0; ls_ready = 0; flush = 1;
    step();
    set_idle();
  endtask

  initial begin
    int t0;
    bit seen;
    rst = 1; flush = 0; alloc_valid = 0; alloc_idx = 0; alloc_class = 0;
    dealloc_valid = 0; dealloc_idx = 0; rdy = '0; ls_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu0_valid", gnt_alu0_valid, 0);
    check("rst_mul_valid",  gnt_mul_valid,  0);
    check("rst_ls_valid",   gnt_ls_valid,   0);
    check("rst_mask",       issued_mask,    0);
    check("rst_mul_busy",   mul_busy,       0);
    rst = 0;

    // two ALU entries allocated two cycles apart
    do_flush();
    do_alloc(3, 0); step(); do_alloc(5, 0);
    rdy = 16'h0028; step(); rdy = '0;
    check("tp_alu0_idx3", gnt_alu0_idx, 3);
`ifdef ISSUE_SEL_ALU1_EN
    check("tp_alu1_idx5", gnt_alu1_idx, 5);
    check("tp_mask_0028", issued_mask, 16'h0028);
`else
    check("tp_mask_0008", issued_mask, 16'h0008);
`endif

    // saturated ages tie: lowest index wins
    do_flush();
    do_alloc(7, 0); do_alloc(2, 0);
    repeat (34) step();
    rdy = 16'h0084; step(); rdy = '0;
    check("tp_tie_idx2", gnt_alu0_idx, 2);

    // MUL throughput window
    do_flush();
    for (int k = 0; k < 4; k++) do_alloc(k, 1);
    rdy = 16'h000F; seen = 0; t0 = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (gnt_mul_valid) begin
        if (!seen) begin
          seen = 1; t0 = cyc;
          exp_q.push_back(32'(t0 + L)); exp_q.push_back(32'(t0 + 2 * L)); exp_q.push_back(32'(t0 + 3 * L));
        end else if (exp_q.size() != 0) begin
          check("tp_mul_grant_cycle", cyc, exp_q.pop_front());
        end else begin
          check("tp_mul_extra_grant", 1, 0);
        end
      end
      if (seen) check("tp_mul_busy", mul_busy, 1);
    end
    check("tp_mul_first_seen", seen, 1);
    check("tp_mul_grants_left", exp_q.size(), 0);
    exp_q.delete();
    rdy = '0;

    // LS hold then back-to-back handoff
    do_flush();
    do_alloc(9, 2); do_alloc(10, 2);
    rdy = 16'h0600; ls_ready = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      check("tp_ls_hold9", {gnt_ls_valid, gnt_ls_idx}, {1'b1, 4'd9});
    end
    ls_ready = 1; step();
    check("tp_ls_next10", {gnt_ls_valid, gnt_ls_idx}, {1'b1, 4'd10});
    ls_ready = 0; rdy = '0;

    // flush while LS held and multiplier mid-window
    do_flush();
    do_alloc(1, 1); do_alloc(2, 2);
    rdy = 16'h0006; ls_ready = 0;
    step(); step();
    flush = 1; step(); flush = 0;
    check("tp_flush_ls", gnt_ls_valid, 0);
    check("tp_flush_busy", mul_busy, 0);
    rdy = 16'hFFFF; step();
    check("tp_flush_noelig", issued_mask, 0);
    rdy = '0;

    // alloc beats dealloc on the same entry
    do_flush();
    alloc_valid = 1; alloc_idx = 4; alloc_class = 0;
    dealloc_valid = 1; dealloc_idx = 4; rdy = 16'h0010;
    step(); set_idle();
    check("tp_ad_nogrant", gnt_alu0_valid, 0);
    step();
    check("tp_ad_grant4", {gnt_alu0_valid, gnt_alu0_idx}, {1'b1, 4'd4});
    rdy = '0;

    // random traffic
    do_flush();
    for (int n = 0; n < 1500; n++) begin
      alloc_valid   = ($urandom_range(0, 1) == 1);
      alloc_idx     = 4'($urandom_range(0, 15));
      alloc_class   = 2'($urandom_range(0, 3));
      dealloc_valid = ($urandom_range(0, 9) < 4);
      dealloc_idx   = 4'($urandom_range(0, 15));
      rdy           = 16'($urandom);
      ls_ready      = ($urandom_range(0, 1) == 1);
      flush         = ($urandom_range(0, 199) == 0);
      step();
    end
    set_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
